// File: rtl/rv32i_types_pkg.sv
// Shared types for the out-of-order writeback path: functional-unit indices
// and small helpers used by the writeback arbiter.
package rv32i_types_pkg;

    // Number of functional units competing for the single writeback port.
    localparam int NUM_WB_FU = 4;

    // Functional-unit index; also the encoding driven on wb_fu.
    typedef enum logic [1:0] {
        FU_AU = 2'd0,
        FU_MU = 2'd1,
        FU_DU = 2'd2,
        FU_LS = 2'd3
    } fu_idx_e;

    // Encode a one-hot grant vector into a functional-unit index.
    // An all-zero vector encodes to FU_AU; callers qualify with |grant.
    function automatic fu_idx_e onehot_to_fu(input logic [NUM_WB_FU-1:0] oh);
        fu_idx_e idx;
        idx = FU_AU;
        for (int i = 0; i < NUM_WB_FU; i++) begin
            if (oh[i]) begin
                idx = fu_idx_e'(2'(i));
            end
        end
        return idx;
    endfunction

    // Round-robin pointer after granting index g: the unit just served
    // becomes lowest priority.
    function automatic logic [1:0] next_ptr(input fu_idx_e g);
        return 2'(g) + 2'd1;
    endfunction

endpackage

// File: rtl/ooo_wb_arbiter_if.sv
// Bundle of the functional-unit request side and the completion-buffer
// writeback side of the writeback arbiter. The arbiter uses the slave
// modport; the surrounding pipeline (or a bench) drives the master side.
interface ooo_wb_arbiter_if #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    import rv32i_types_pkg::*;

    // Control from the hazard unit and completion buffer
    logic                                flush;
    logic                                cb_ready;

    // Per-FU result requests (index 0=AU, 1=MU, 2=DU, 3=LS)
    logic [NUM_WB_FU-1:0]                req;
    logic [NUM_WB_FU-1:0][TAG_W-1:0]     req_tag;
    logic [NUM_WB_FU-1:0][DATA_W-1:0]    req_data;
    logic [NUM_WB_FU-1:0]                req_exc;

    // Combinational handshake back to the FUs
    logic [NUM_WB_FU-1:0]                grant;
    logic [NUM_WB_FU-1:0]                stall;
    logic                                wb_port_conflict;

    // Registered writeback to the completion buffer
    logic                                wb_valid;
    fu_idx_e                             wb_fu;
    logic [TAG_W-1:0]                    wb_tag;
    logic [DATA_W-1:0]                   wb_data;
    logic                                wb_exc;

    modport master (
        output flush, cb_ready, req, req_tag, req_data, req_exc,
        input  grant, stall, wb_port_conflict,
        input  wb_valid, wb_fu, wb_tag, wb_data, wb_exc
    );

    modport slave (
        input  flush, cb_ready, req, req_tag, req_data, req_exc,
        output grant, stall, wb_port_conflict,
        output wb_valid, wb_fu, wb_tag, wb_data, wb_exc
    );

endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter. Searches req starting at index ptr and
// wrapping, granting the first requester found. Purely combinational; the
// pointer is owned by the caller. accept=0 suppresses every grant.
module rr_arbiter_4
    import rv32i_types_pkg::*;
(
    input  logic [NUM_WB_FU-1:0] req,
    input  logic [1:0]           ptr,
    input  logic                 accept,
    output logic [NUM_WB_FU-1:0] grant
);

    // rot_req[k] is the requester visited k-th in the search order
    logic [NUM_WB_FU-1:0] rot_req;
    // Lowest set bit of rot_req: the winner, still in search-order position
    logic [NUM_WB_FU-1:0] rot_win;

    // Rotate requests so that position 0 is the current pointer
    for (genvar gi = 0; gi < NUM_WB_FU; gi++) begin : g_rotate
        localparam logic [1:0] OFS = 2'(gi);
        assign rot_req[gi] = req[OFS + ptr];
    end

    // Isolate the first requester in search order
    always_comb begin
        rot_win = rot_req & (~rot_req + 4'd1);
    end

    // Rotate the winner back to its physical FU index
    for (genvar gi = 0; gi < NUM_WB_FU; gi++) begin : g_unrotate
        localparam logic [1:0] OFS = 2'(gi);
        assign grant[gi] = accept & rot_win[OFS - ptr];
    end

endmodule

// File: rtl/ooo_wb_arbiter.sv
// Writeback arbiter for the out-of-order core. Four functional units share
// one completion-buffer write port. One requester is granted per accepting
// cycle in round-robin order and its result is registered onto wb_*, so a
// granted result appears on wb_valid one cycle after its request. Losers are
// stalled and must hold their request; nothing is buffered here.
module ooo_wb_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    ooo_wb_arbiter_if.slave   bus
);

    // The output register can take new content when empty or being drained
    logic                  accept;
    logic                  arb_en;
    logic [NUM_WB_FU-1:0]  grant_raw;
    logic [NUM_WB_FU-1:0]  grant_vec;
    logic                  any_grant;
    fu_idx_e               grant_idx;

    logic [1:0]            ptr_reg;
    logic [1:0]            ptr_next;

    logic                  wb_valid_reg;
    logic                  wb_valid_next;
    fu_idx_e               wb_fu_reg;
    fu_idx_e               wb_fu_next;
    logic [TAG_W-1:0]      wb_tag_reg;
    logic [TAG_W-1:0]      wb_tag_next;
    logic [DATA_W-1:0]     wb_data_reg;
    logic [DATA_W-1:0]     wb_data_next;
    logic                  wb_exc_reg;
    logic                  wb_exc_next;

    assign accept = !wb_valid_reg || bus.cb_ready;
    assign arb_en = accept && !bus.flush;

    rr_arbiter_4 u_rr (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .accept (arb_en),
        .grant  (grant_raw)
    );

    // No unit may believe it was accepted while the core is held in reset
    assign grant_vec = grant_raw & {NUM_WB_FU{nRST}};
    assign any_grant = |grant_raw;
    assign grant_idx = onehot_to_fu(grant_raw);

    assign bus.grant            = grant_vec;
    assign bus.stall            = bus.req & ~grant_vec;
    // More than one requester: clearing the lowest set bit leaves something
    assign bus.wb_port_conflict = |(bus.req & (bus.req - 4'd1));

    assign bus.wb_valid = wb_valid_reg;
    assign bus.wb_fu    = wb_fu_reg;
    assign bus.wb_tag   = wb_tag_reg;
    assign bus.wb_data  = wb_data_reg;
    assign bus.wb_exc   = wb_exc_reg;

    // Next-state for the writeback register and round-robin pointer.
    // Flush kills any pending output and leaves the pointer alone; otherwise
    // an accepting cycle either loads the winner or empties the register.
    always_comb begin
        wb_valid_next = wb_valid_reg;
        wb_fu_next    = wb_fu_reg;
        wb_tag_next   = wb_tag_reg;
        wb_data_next  = wb_data_reg;
        wb_exc_next   = wb_exc_reg;
        ptr_next      = ptr_reg;

        if (bus.flush) begin
            wb_valid_next = 1'b0;
        end else if (accept) begin
            if (any_grant) begin
                wb_valid_next = 1'b1;
                wb_fu_next    = grant_idx;
                wb_tag_next   = bus.req_tag[grant_idx];
                wb_data_next  = bus.req_data[grant_idx];
                wb_exc_next   = bus.req_exc[grant_idx];
                ptr_next      = next_ptr(grant_idx);
            end else begin
                wb_valid_next = 1'b0;
            end
        end
    end

    // State registers; reset empties the output and gives AU top priority
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid_reg <= 1'b0;
            wb_fu_reg    <= FU_AU;
            wb_tag_reg   <= '0;
            wb_data_reg  <= '0;
            wb_exc_reg   <= 1'b0;
            ptr_reg      <= 2'd0;
        end else begin
            wb_valid_reg <= wb_valid_next;
            wb_fu_reg    <= wb_fu_next;
            wb_tag_reg   <= wb_tag_next;
            wb_data_reg  <= wb_data_next;
            wb_exc_reg   <= wb_exc_next;
            ptr_reg      <= ptr_next;
        end
    end

endmodule

// File: tb/tb_ooo_wb_arbiter.sv
// Self-checking bench for ooo_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that picks
// winners by walking the round-robin order with plain modular arithmetic.
module tb_ooo_wb_arbiter;
    import rv32i_types_pkg::*;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic nRST;

    ooo_wb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    ooo_wb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int                 m_ptr;
    logic               m_valid;
    logic [1:0]         m_fu;
    logic [TAG_W-1:0]   m_tag;
    logic [DATA_W-1:0]  m_data;
    logic               m_exc;
    int                 wait_cnt [4];

    logic [3:0]         last_grant;
    logic [3:0]         last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_fu    = 2'd0;
        m_tag   = '0;
        m_data  = '0;
        m_exc   = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        last_grant = 4'b0000;
    endtask

    task automatic set_fu(input int i, input logic r, input logic [TAG_W-1:0] t,
                          input logic [DATA_W-1:0] d, input logic e);
        bus.req[i]      = r;
        bus.req_tag[i]  = t;
        bus.req_data[i] = d;
        bus.req_exc[i]  = e;
    endtask

    // Called at posedge+1 with inputs already applied. Checks the
    // combinational outputs mid-cycle, then the registered outputs after
    // the next rising edge.
    task automatic cycle();
        logic       acc;
        int         g;
        int         nbits;
        logic [3:0] gexp;
        logic [3:0] sexp;
        logic       starve;
        #2;
        acc = !m_valid || bus.cb_ready;
        g = -1;
        if (nRST && acc && !bus.flush) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (g < 0 && bus.req[i]) g = i;
            end
        end
        gexp = 4'b0000;
        if (g >= 0) gexp[g] = 1'b1;
        sexp = bus.req & ~gexp;
        nbits = 0;
        for (int i = 0; i < 4; i++) if (bus.req[i]) nbits++;
        last_grant = bus.grant;
        last_stall = bus.stall;
        chk("grant", bus.grant, gexp);
        chk("stall", bus.stall, sexp);
        chk("conflict", bus.wb_port_conflict, nbits > 1);

        starve = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!bus.req[i]) wait_cnt[i] = 0;
            else if (nRST && acc && !bus.flush) begin
                if (bus.grant[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
            end
            if (wait_cnt[i] >= 4) starve = 1'b1;
        end
        chk("no_starvation", starve, 1'b0);

        @(posedge CLK);
        #1;
        if (nRST) begin
            if (bus.flush) m_valid = 1'b0;
            else if (acc) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_fu    = 2'(g);
                    m_tag   = bus.req_tag[g];
                    m_data  = bus.req_data[g];
                    m_exc   = bus.req_exc[g];
                    m_ptr   = (g + 1) % 4;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        chk("wb_valid", bus.wb_valid, m_valid);
        if (m_valid) begin
            chk("wb_fu", bus.wb_fu, m_fu);
            chk("wb_tag", bus.wb_tag, m_tag);
            chk("wb_data", bus.wb_data, m_data);
            chk("wb_exc", bus.wb_exc, m_exc);
        end
        if (g >= 0)
            $display("[TB] t=%0t req=%b grant=%b wb_fu=%0d wb_tag=0x%0h wb_data=0x%0h",
                     $time, bus.req, last_grant, bus.wb_fu, bus.wb_tag, bus.wb_data);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        nRST = 1'b0;
        #1;
        chk({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
        chk({tag, "_wb_fu"}, bus.wb_fu, 2'd0);
        chk({tag, "_wb_tag"}, bus.wb_tag, 0);
        chk({tag, "_wb_data"}, bus.wb_data, 0);
        chk({tag, "_wb_exc"}, bus.wb_exc, 1'b0);
        chk({tag, "_grant"}, bus.grant, 4'b0000);
        chk({tag, "_stall"}, bus.stall, bus.req);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    logic [TAG_W-1:0]  s_tag;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        s_fu;
    logic [3:0]        exp_g;

    initial begin
        nRST         = 1'b0;
        bus.flush    = 1'b0;
        bus.cb_ready = 1'b1;
        bus.req      = 4'b0101;
        bus.req_tag  = '0;
        bus.req_data = '0;
        bus.req_exc  = '0;
        model_reset();

        // Reset state with requests present
        #3;
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_fu", bus.wb_fu, 2'd0);
        chk("rst_wb_tag", bus.wb_tag, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_exc", bus.wb_exc, 1'b0);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_stall", bus.stall, 4'b0101);
        @(posedge CLK);
        #1;
        nRST    = 1'b1;
        bus.req = 4'b0000;

        // Single AU request: same-cycle grant, one-cycle writeback
        set_fu(0, 1'b1, 6'd5, 32'hA, 1'b0);
        cycle();
        chk("t030_grant", last_grant, 4'b0001);
        chk("t030_wb_valid", bus.wb_valid, 1'b1);
        chk("t030_wb_fu", bus.wb_fu, 2'd0);
        chk("t030_wb_tag", bus.wb_tag, 6'd5);
        chk("t030_wb_data", bus.wb_data, 32'hA);

        bus.req = 4'b0000;
        do_reset("rst_mid1");

        // All four requesting: rotate through AU, MU, DU, LS
        for (int i = 0; i < 4; i++)
            set_fu(i, 1'b1, TAG_W'(i + 1), $urandom, i[0]);
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            cycle();
            chk("t031_grant", last_grant, exp_g);
            chk("t031_stall", last_stall, ~exp_g & 4'b1111);
        end

        // Completion buffer back-pressure holds the pending output
        bus.req      = 4'b0100;
        bus.cb_ready = 1'b0;
        s_tag  = bus.wb_tag;
        s_data = bus.wb_data;
        s_fu   = bus.wb_fu;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t032_grant", last_grant, 4'b0000);
            chk("t032_stall", last_stall, 4'b0100);
            chk("t032_hold_valid", bus.wb_valid, 1'b1);
            chk("t032_hold_tag", bus.wb_tag, s_tag);
            chk("t032_hold_data", bus.wb_data, s_data);
            chk("t032_hold_fu", bus.wb_fu, s_fu);
        end
        bus.cb_ready = 1'b1;
        cycle();
        chk("t032_release_grant", last_grant, 4'b0100);

        // Flush suppresses grant and empties the output register
        bus.req   = 4'b0010;
        bus.flush = 1'b1;
        cycle();
        chk("t033_grant", last_grant, 4'b0000);
        chk("t033_stall", last_stall, 4'b0010);
        chk("t033_wb_valid", bus.wb_valid, 1'b0);
        bus.flush = 1'b0;
        cycle();
        chk("t033_after_grant", last_grant, 4'b0010);

        // Pointer wrap: ptr=3 serves LS before AU
        bus.req = 4'b0100;
        cycle();
        bus.req = 4'b1001;
        cycle();
        chk("t034_grant_ls", last_grant, 4'b1000);
        cycle();
        chk("t034_grant_au", last_grant, 4'b0001);

        // Reset mid-cycle discards the pending writeback immediately
        chk("t035_pre_valid", bus.wb_valid, 1'b1);
        do_reset("t035");

        // Randomized traffic; stalled units keep their request stable
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(bus.req[i] && !last_grant[i])) begin
                    bus.req[i]      = ($urandom % 3) != 0;
                    bus.req_tag[i]  = TAG_W'($urandom);
                    bus.req_data[i] = $urandom;
                    bus.req_exc[i]  = ($urandom % 8) == 0;
                end
            end
            bus.cb_ready = ($urandom % 4) != 0;
            bus.flush    = ($urandom % 12) == 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ooo_wb_arbiter.md
OOO_WB_ARBITER -- requirements
Module: ooo_wb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  execute_commit_flush from the hazard unit.
REQ-006 SHALL have port cb_ready  input  1  completion buffer accepts a writeback this cycle.
REQ-007 SHALL have port req  input  4  per-FU result valid; index 0=AU, 1=MU, 2=DU, 3=LS.
REQ-008 SHALL have port req_tag  input  4xTAG_W  per-FU ROB tag.
REQ-009 SHALL have port req_data  input  4xDATA_W  per-FU result.
REQ-010 SHALL have port req_exc  input  4  per-FU exception flag.
REQ-011 SHALL have port grant  output  4  one-hot accept to FUs; combinational.
REQ-012 SHALL have port stall  output  4  stall_au/mu/du/ls = req & ~grant; combinational.
REQ-013 SHALL have port wb_port_conflict  output  1  more than one req bit set; combinational.
REQ-014 SHALL have port wb_valid, wb_fu(2), wb_tag(TAG_W), wb_data(DATA_W), wb_exc  output  registered writeback to the completion buffer.

Function
REQ-015 SHALL define accept = !wb_valid || cb_ready.
REQ-016 SHALL assert at most one grant bit, only when accept && !flush && req != 0.
REQ-017 SHALL select round-robin: search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4), granting the first set req.
REQ-018 SHALL update ptr to (g+1) mod 4 on the edge after grant at index g; ptr unchanged otherwise, including during flush.
REQ-019 SHALL load wb_* from the granted FU on the same edge, giving one-cycle latency req->wb_valid.
REQ-020 SHALL clear wb_valid when accept holds and no grant issues; wb_valid holds its content while !cb_ready.
REQ-021 SHALL on flush force grant=0 and clear wb_valid on the next edge, overriding a pending output.
REQ-022 SHALL require FUs to hold req/tag/data stable while stall is asserted; the arbiter does not buffer losers.
REQ-023 SHALL grant every continuously requesting FU within 4 accepting cycles (no starvation).
REQ-024 SHALL drive wb_fu as the encoded granted index.
REQ-025 SHALL treat wb_port_conflict as independent of accept and flush.

Reset
REQ-026 SHALL on nRST low asynchronously clear wb_valid, wb_fu, wb_tag, wb_data, wb_exc to 0 and set ptr to 0 (AU highest).
REQ-027 SHALL while nRST is low hold grant=0 and stall=req; a reset mid-output discards the pending writeback.

Structure
REQ-028 SHALL place the FU index typedef (AU/MU/DU/LS, 2 bits) and NUM_WB_FU=4 in rv32i_types_pkg.
REQ-029 SHALL use one sub-module rr_arbiter_4 (req, ptr, accept -> one-hot grant); output register and ptr live in ooo_wb_arbiter.

Verification
REQ-030 SHALL test: reset, req=0001 tag=5 data=0xA, cb_ready=1 -> grant=0001 same cycle; next cycle wb_valid=1, wb_fu=0, wb_tag=5, wb_data=0xA.
REQ-031 SHALL test: req=1111 held, cb_ready=1 for 4 cycles -> grants 0001,0010,0100,1000 in order; wb_port_conflict=1; stall=~grant&1111 each cycle.
REQ-032 SHALL test: wb_valid=1, cb_ready=0, req=0100 for 3 cycles -> grant=0, stall=0100, wb_* unchanged; cb_ready=1 -> grant=0100 that cycle.
REQ-033 SHALL test: req=0010 with flush=1 -> grant=0, stall=0010, wb_valid=0 next cycle, ptr unchanged (next grant after flush still 0010).
REQ-034 SHALL test: ptr=3, req=1001 -> grant=1000; next cycle req=1001 -> grant=0001.
REQ-035 SHALL test: nRST dropped mid-cycle with wb_valid=1 -> wb_valid=0 immediately, without waiting for CLK.
